// File: rtl/serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg
//   Shared types and helpers for the chunk-serial adder/subtractor.
//   - addsub_state_t : controller states (IDLE -> RUN -> DONE -> IDLE)
//   - cnt_width()    : width of the chunk counter for a given chunk count
// ---------------------------------------------------------------------------
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    // The counter has to hold values 0..nchunk, so it needs one state more
    // than the number of chunks. The result is never narrower than one bit.
    function automatic int cnt_width(input int nchunk);
        int w;
        w = $clog2(nchunk + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_adder_chunk.sv
// ---------------------------------------------------------------------------
// full_adder / adder_chunk
//   Combinational building blocks for the serial adder/subtractor.
//
//   full_adder : one-bit full adder.
//     a, b, cin : inputs
//     s         : sum bit
//     cout      : carry out
//
//   adder_chunk #(CHUNK) : CHUNK-bit ripple of full_adder cells.
//     a, b   [CHUNK-1:0] : operand slices
//     cin                : carry into bit 0
//     s      [CHUNK-1:0] : sum slice
//     cout               : carry out of the top bit
//     c_msb              : carry into the top bit (for signed overflow)
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder

module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    import serial_addsub_pkg::*;

    // c[i] is the carry into bit i; c[CHUNK] leaves the chunk.
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule : adder_chunk

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle WIDTH-bit adder/subtractor. Adds CHUNK bits per clock with a
//   small ripple adder and carries between chunks in a register, so a full
//   operation takes NCHUNK = WIDTH/CHUNK RUN cycles plus one DONE cycle.
//
// Parameters
//   WIDTH : operand/result width
//   CHUNK : bits processed per cycle, must divide WIDTH
//
// Ports
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous reset, active-low
//   start in  1      operation request, sampled only in IDLE
//   sub   in  1      0: a+b, 1: a-b (sampled with start)
//   a     in  WIDTH  operand A (sampled with start)
//   b     in  WIDTH  operand B (sampled with start)
//   busy  out 1      high while the chunks are being processed
//   done  out 1      one-cycle pulse when sum/cout/ovf are valid
//   sum   out WIDTH  result, held until the next accepted start
//   cout  out 1      carry out of the MSB (in sub mode: 1 = no borrow)
//   ovf   out 1      signed overflow
// ---------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);

    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
        $error("serial_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    addsub_state_t state;
    addsub_state_t state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    // -----------------------------------------------------------------------
    // Chunk adder on the low slice of the operand shift registers
    // -----------------------------------------------------------------------
    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;
    logic             ch_cmsb;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (opa[CHUNK-1:0]),
        .b     (opb[CHUNK-1:0]),
        .cin   (carry),
        .s     (ch_s),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    // Shifts are written through a widened concatenation so that the
    // CHUNK == WIDTH case (no bits left over) needs no special casing.
    logic [WIDTH+CHUNK-1:0] sum_cat;
    logic [WIDTH+CHUNK-1:0] opa_cat;
    logic [WIDTH+CHUNK-1:0] opb_cat;
    logic [WIDTH-1:0]       sum_shift;
    logic [WIDTH-1:0]       opa_shift;
    logic [WIDTH-1:0]       opb_shift;
    logic                   last_chunk;

    assign sum_cat   = {ch_s, sum_r};
    assign opa_cat   = {{CHUNK{1'b0}}, opa};
    assign opb_cat   = {{CHUNK{1'b0}}, opb};
    assign sum_shift = sum_cat[WIDTH+CHUNK-1:CHUNK];
    assign opa_shift = opa_cat[WIDTH+CHUNK-1:CHUNK];
    assign opb_shift = opb_cat[WIDTH+CHUNK-1:CHUNK];

    assign last_chunk = (cnt == CNT_W'(NCHUNK - 1));

    // -----------------------------------------------------------------------
    // Controller: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Controller: next state and status outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: operand capture, chunk stepping, result capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the
                        // carry with 1.
                        opa    <= a;
                        opb    <= sub ? ~b : b;
                        carry  <= sub;
                        cnt    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r <= sum_shift;
                    opa   <= opa_shift;
                    opb   <= opb_shift;
                    carry <= ch_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_chunk) begin
                        cout_r <= ch_cout;
                        ovf_r  <= ch_cmsb ^ ch_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Scoreboard bench for serial_addsub. Three instances run side by side:
//   CHUNK=4 (main), CHUNK=8 and CHUNK=32, all WIDTH=32. Stimulus pushes the
//   expected result and the expected done cycle into a per-instance queue;
//   a monitor pops and compares whenever an instance raises done.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start0;
    logic        start1;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    logic        bz [3];
    logic        dn [3];
    logic [31:0] sm [3];
    logic        co [3];
    logic        ov [3];

    logic [31:0] cyc;
    int          checks;
    int          errors;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    serial_addsub #(.WIDTH(32), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub), .a(a), .b(b),
        .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .cout(co[0]), .ovf(ov[0])
    );

    serial_addsub #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
        .busy(bz[1]), .done(dn[1]), .sum(sm[1]), .cout(co[1]), .ovf(ov[1])
    );

    serial_addsub #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
        .busy(bz[2]), .done(dn[2]), .sum(sm[2]), .cout(co[2]), .ovf(ov[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cmp(input int k, input exp_t e);
        chk($sformatf("sum_dut%0d", k),  sm[k], e.sum);
        chk($sformatf("cout_dut%0d", k), 32'(co[k]), 32'(e.cout));
        chk($sformatf("ovf_dut%0d", k),  32'(ov[k]), 32'(e.ovf));
        chk($sformatf("done_cycle_dut%0d", k), cyc, e.cyc);
    endtask

    task automatic no_exp(input int k);
        checks++;
        errors++;
        $display("FAIL unexpected_done_dut%0d actual=1 required=0 (cycle %0d)", k, cyc);
    endtask

    // Monitor: every done pulse must match the head of its queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (dn[0]) begin
            if (q0.size() == 0) no_exp(0);
            else begin e = q0.pop_front(); cmp(0, e); end
        end
        if (dn[1]) begin
            if (q1.size() == 0) no_exp(1);
            else begin e = q1.pop_front(); cmp(1, e); end
        end
        if (dn[2]) begin
            if (q2.size() == 0) no_exp(2);
            else begin e = q2.pop_front(); cmp(2, e); end
        end
    end

    // Independent 33-bit reference.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic s);
        exp_t        r;
        logic [32:0] f;
        f = s ? ({1'b0, av} - {1'b0, bv} + 33'h1_0000_0000) : ({1'b0, av} + {1'b0, bv});
        r.sum  = f[31:0];
        r.cout = f[32];
        if (s) r.ovf = (av[31] != bv[31]) && (f[31] != av[31]);
        else   r.ovf = (av[31] == bv[31]) && (f[31] != av[31]);
        r.cyc  = '0;
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required=0 pending results", q0.size() + q1.size() + q2.size());
            q0.delete();
            q1.delete();
            q2.delete();
        end
    endtask

    // One operation; all=1 also sends it to the CHUNK=8 and CHUNK=32 instances.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s,
                         input logic all, input exp_t e_in);
        exp_t        e;
        logic [31:0] acc;
        e = e_in;
        @(posedge clk); #1;
        a = av; b = bv; sub = s; start0 = 1'b1; start1 = all;
        @(posedge clk); #1;
        acc = cyc;
        start0 = 1'b0; start1 = 1'b0;
        a = ~av; b = ~bv; sub = ~s;
        e.cyc = acc + 32'd8; q0.push_back(e);
        if (all) begin
            e.cyc = acc + 32'd4; q1.push_back(e);
            e.cyc = acc + 32'd1; q2.push_back(e);
        end
        wait_idle();
    endtask

    function automatic exp_t hand(input vec_t v);
        exp_t e;
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf; e.cyc = '0;
        return e;
    endfunction

    vec_t dir [6];
    vec_t thr [4];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; cyc = '0;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; sub = 1'b0; a = '0; b = '0;

        //            a             b             sub   sum           cout  ovf
        dir[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        dir[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        dir[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        dir[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        dir[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        dir[5] = '{32'h0000_000A, 32'h0000_000A, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        thr[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        thr[1] = '{32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 1'b1, 1'b0};
        thr[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        thr[3] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy_dut%0d", k), 32'(bz[k]), 32'd0);
            chk($sformatf("rst_done_dut%0d", k), 32'(dn[k]), 32'd0);
            chk($sformatf("rst_sum_dut%0d", k),  sm[k], 32'd0);
            chk($sformatf("rst_cout_dut%0d", k), 32'(co[k]), 32'd0);
            chk($sformatf("rst_ovf_dut%0d", k),  32'(ov[k]), 32'd0);
        end

        // Directed add/sub on all three chunk sizes
        for (int i = 0; i < 5; i++) begin
            issue(dir[i].a, dir[i].b, dir[i].sub, 1'b1, hand(dir[i]));
        end

        // Reset in the third RUN cycle aborts with no done pulse
        @(posedge clk); #1;
        a = 32'h0000_0077; b = 32'h0000_0011; sub = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_busy", 32'(bz[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        chk("abort_sum",  sm[0], 32'd0);
        repeat (15) @(posedge clk);
        issue(dir[5].a, dir[5].b, dir[5].sub, 1'b1, hand(dir[5]));

        // start held high, operands scrambled while busy
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            a = thr[k].a; b = thr[k].b; sub = thr[k].sub; start0 = 1'b1;
            @(posedge clk); #1;
            e = hand(thr[k]);
            e.cyc = cyc + 32'd8;
            q0.push_back(e);
            for (int j = 0; j < 9; j++) begin
                a = $urandom(); b = $urandom(); sub = 1'(j & 1);
                @(posedge clk); #1;
            end
        end
        start0 = 1'b0;
        wait_idle();

        // Random operations on all three chunk sizes
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] av;
            logic [31:0] bv;
            logic        s;
            av = $urandom();
            bv = $urandom();
            s  = 1'($urandom_range(0, 1));
            issue(av, bv, s, 1'b1, model(av, bv, s));
        end

        repeat (12) @(posedge clk);
        chk("pending_results", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_addsub
